// File: rtl/mb_sp_ram.sv
// mb_sp_ram: multi-port, word-interleaved banked SRAM.
// NUM_PORTS masters share NUM_BANKS single-port banks. Each bank has its own
// round-robin arbiter, so masters hitting different banks proceed together.
//
// Handshake (per port p): the master raises req_i[p] with addr/we/wdata/be
// and holds all of them stable until gnt_o[p]=1 in the same cycle (gnt_o is
// combinational). The access takes effect on that rising edge. Exactly one
// rvalid_o[p] pulse follows 1+OUT_REG cycles later, for reads and writes
// alike; rdata_o[p] only changes on read responses. There is no back-pressure
// on the response side.
module mb_sp_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int OUT_REG    = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_PORTS-1:0]                     req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_PORTS-1:0]                     we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i,
    output logic [NUM_PORTS-1:0]                     gnt_o,
    output logic [NUM_PORTS-1:0]                     rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int ROWS   = NUM_WORDS / NUM_BANKS;
    localparam int BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Decoded per-port location: word wraps modulo NUM_WORDS, low word bits
    // select the bank, the remaining bits select the row inside it.
    logic [31:0]                    w_word [NUM_PORTS];
    logic [NUM_PORTS-1:0][BW-1:0]   w_bank;
    logic [NUM_PORTS-1:0][RW-1:0]   w_row;

    // Arbitration state and results.
    logic [PW-1:0]                  r_rr_ptr   [NUM_BANKS];
    logic [PW-1:0]                  w_next_ptr [NUM_BANKS];
    logic [NUM_BANKS-1:0]           w_bank_gnt;
    logic [NUM_PORTS-1:0]           w_gnt;

    // Storage: one array per bank, rows of full words.
    logic [DATA_WIDTH-1:0]          r_mem [NUM_BANKS][ROWS];

    // First response stage (the outputs when OUT_REG=0).
    logic [NUM_PORTS-1:0]                   r_v1;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   r_d1;

    // Address decode: byte address -> (bank, row), ignoring bits above the array.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_word[p] = 32'(addr_i[p] >> OFF) % 32'(NUM_WORDS);
            w_bank[p] = BW'(w_word[p] % 32'(NUM_BANKS));
            w_row[p]  = RW'(w_word[p] / 32'(NUM_BANKS));
        end
    end

    // Per-bank round-robin: first requesting port at or after the pointer wins.
    always_comb begin
        int   v_idx;
        logic v_found;
        v_idx      = 0;
        v_found    = 1'b0;
        w_gnt      = '0;
        w_bank_gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_next_ptr[b] = r_rr_ptr[b];
            v_found       = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                v_idx = (int'(r_rr_ptr[b]) + k) % NUM_PORTS;
                if (!v_found && req_i[v_idx] && (w_bank[v_idx] == BW'(b))) begin
                    v_found       = 1'b1;
                    w_bank_gnt[b] = 1'b1;
                    w_gnt[v_idx]  = 1'b1;
                    w_next_ptr[b] = PW'((v_idx + 1) % NUM_PORTS);
                end
            end
        end
    end

    assign gnt_o = w_gnt;

    // Round-robin pointers advance past the winner only on granting cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_rr_ptr[b] <= w_next_ptr[b];
            end
        end
    end

    // Byte-masked writes; at most one granted port per bank, none during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gnt[p] && we_i[p]) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (be_i[p][i]) begin
                            r_mem[w_bank[p]][w_row[p]][i*8 +: 8] <= wdata_i[p][i*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Response stage: valid for every grant, data captured (pre-write) on reads only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= '0;
            r_d1 <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_v1[p] <= w_gnt[p];
                if (w_gnt[p] && !we_i[p]) begin
                    r_d1[p] <= r_mem[w_bank[p]][w_row[p]];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_PORTS-1:0]                   r_rd1;
        logic [NUM_PORTS-1:0]                   r_v2;
        logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   r_d2;

        // Extra output stage: delays valid by one cycle, data moves only on reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd1 <= '0;
                r_v2  <= '0;
                r_d2  <= '0;
            end else begin
                r_rd1 <= w_gnt & ~we_i;
                r_v2  <= r_v1;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (r_v1[p] && r_rd1[p]) begin
                        r_d2[p] <= r_d1[p];
                    end
                end
            end
        end

        assign rvalid_o = r_v2;
        assign rdata_o  = r_d2;
    end else begin : g_no_out_reg
        assign rvalid_o = r_v1;
        assign rdata_o  = r_d1;
    end

endmodule

// File: tb/tb_mb_sp_ram.sv
// Bench for mb_sp_ram: two instances (OUT_REG=0 and OUT_REG=1) share the same
// stimulus. A reference model (flat word array + per-bank pointer) predicts
// grants and responses; a monitor pops the expected queues on every rvalid.
module tb_mb_sp_ram;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NW  = 1024;
  localparam int NP  = 2;
  localparam int NB  = 4;
  localparam int BEW = DW / 8;
  localparam int OFF = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]          req, we;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][DW-1:0]  wdata;
  logic [NP-1:0][BEW-1:0] be;
  logic [NP-1:0]          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [NP-1:0][DW-1:0]  rdata_a, rdata_b;

  mb_sp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_PORTS(NP),
              .NUM_BANKS(NB), .OUT_REG(0)) dut_a (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a));

  mb_sp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_PORTS(NP),
              .NUM_BANKS(NB), .OUT_REG(1)) dut_b (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b));

  // ---------------- model / scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [DW-1:0] mem_m   [NW];
  int            ptr_m   [NB];
  logic [DW-1:0] last_rd [NP];
  logic [NP-1:0] exp_gnt;
  // entry = {due cycle, expected rdata}; queue index = dut*NP + port
  logic [63:0]   exp_q   [2*NP][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return (int'(a) >> OFF) % NW;
  endfunction

  // Predict this cycle's grants, compare them, and record the consequences.
  task automatic model_cycle();
    int  w;
    int  idx;
    int  win [NB];
    bit  found [NB];
    exp_gnt = '0;
    for (int bk = 0; bk < NB; bk++) begin
      found[bk] = 1'b0;
      win[bk]   = 0;
      for (int k = 0; k < NP; k++) begin
        idx = (ptr_m[bk] + k) % NP;
        if (!found[bk] && req[idx] && (word_of(addr[idx]) % NB == bk)) begin
          found[bk]    = 1'b1;
          win[bk]      = idx;
          exp_gnt[idx] = 1'b1;
        end
      end
    end
    check("gnt_a", gnt_a, exp_gnt);
    check("gnt_b", gnt_b, exp_gnt);
    if (rst) begin
      for (int bk = 0; bk < NB; bk++) ptr_m[bk] = 0;
    end else begin
      // reads see the memory before any same-edge write
      for (int p = 0; p < NP; p++) begin
        if (exp_gnt[p]) begin
          if (!we[p]) last_rd[p] = mem_m[word_of(addr[p])];
          exp_q[p].push_back({32'(cyc + 1), last_rd[p]});
          exp_q[NP + p].push_back({32'(cyc + 2), last_rd[p]});
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (exp_gnt[p] && we[p]) begin
          w = word_of(addr[p]);
          for (int i = 0; i < BEW; i++)
            if (be[p][i]) mem_m[w][i*8 +: 8] = wdata[p][i*8 +: 8];
        end
      end
      for (int bk = 0; bk < NB; bk++)
        if (found[bk]) ptr_m[bk] = (win[bk] + 1) % NP;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BEW-1:0] b);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick(input bit chk_g = 1'b0, input logic [NP-1:0] g_req = '0);
    @(negedge clk);
    if (chk_g) check("rr_sequence", gnt_a, g_req);
    model_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic new_txn(input int p);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 4095));
    drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
          BEW'($urandom_range(0, 15)));
  endtask

  task automatic clear_model_outputs();
    for (int q = 0; q < 2*NP; q++) exp_q[q].delete();
    for (int p = 0; p < NP; p++) last_rd[p] = '0;
    for (int bk = 0; bk < NB; bk++) ptr_m[bk] = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rvalid_a"}, rvalid_a, '0);
    check({tag, "_rvalid_b"}, rvalid_b, '0);
    check({tag, "_rdata_a"}, rdata_a, '0);
    check({tag, "_rdata_b"}, rdata_b, '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic        v;
    logic [DW-1:0] dat;
    logic [63:0] e;
    int          q;
    if (mon_en && !rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          q   = d * NP + p;
          v   = (d == 0) ? rvalid_a[p] : rvalid_b[p];
          dat = (d == 0) ? rdata_a[p] : rdata_b[p];
          if (v) begin
            if (exp_q[q].size() == 0) begin
              check($sformatf("unexpected_rvalid d%0d p%0d", d, p), v, 1'b0);
            end else begin
              e = exp_q[q].pop_front();
              check($sformatf("rvalid_cycle d%0d p%0d", d, p), 64'(cyc), 64'(e[63:32]));
              check($sformatf("rdata d%0d p%0d", d, p), dat, e[DW-1:0]);
            end
          end else if (exp_q[q].size() != 0 && int'(exp_q[q][0][63:32]) <= cyc) begin
            e = exp_q[q].pop_front();
            check($sformatf("missing_rvalid d%0d p%0d", d, p), v, 1'b1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] raw_val;
  logic [NP-1:0] rr_pat [4];

  initial begin
    rst = 1'b1;
    idle_all();
    clear_model_outputs();
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // preload every word: the two ports always land on different banks
    for (int i = 0; i < NW/2; i++) begin
      drive(0, 1'b1, 1'b1, AW'((2*i) << OFF), $urandom, '1);
      drive(1, 1'b1, 1'b1, AW'((2*i + 1) << OFF), $urandom, '1);
      tick();
    end
    idle_all();
    tick();

    // single port write then read
    drive(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF); tick();
    drive(0, 1'b1, 1'b0, 12'h010, '0, '0);             tick();
    idle_all(); tick(); tick();
    check("t1_rdata_a", rdata_a[0], 32'hDEADBEEF);
    check("t1_rdata_b", rdata_b[0], 32'hDEADBEEF);

    // byte enables, including an empty mask
    drive(0, 1'b1, 1'b1, 12'h020, 32'h11223344, 4'hF); tick();
    drive(0, 1'b1, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5); tick();
    drive(0, 1'b1, 1'b0, 12'h020, '0, '0);             tick();
    drive(0, 1'b1, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0); tick();
    drive(0, 1'b1, 1'b0, 12'h020, '0, '0);             tick();
    idle_all(); tick(); tick();
    check("be_rdata_a", rdata_a[0], 32'h11BB33DD);
    check("be_rdata_b", rdata_b[0], 32'h11BB33DD);

    // parallel reads on banks 0 and 1
    drive(0, 1'b1, 1'b0, 12'h000, '0, '0);
    drive(1, 1'b1, 1'b0, 12'h004, '0, '0);
    tick();
    idle_all(); tick(); tick();

    // sustained conflict on bank 2
    drive(0, 1'b1, 1'b0, 12'h008, '0, '0);
    drive(1, 1'b1, 1'b0, 12'h018, '0, '0);
    repeat (4) tick();
    idle_all(); tick(); tick();

    // cross-port read-after-write to the same word
    raw_val = $urandom;
    drive(1, 1'b1, 1'b1, 12'h030, raw_val, 4'hF); tick();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 1'b0, 12'h030, '0, '0);        tick();
    idle_all(); tick(); tick();
    check("raw_rdata_a", rdata_a[0], raw_val);
    check("raw_rdata_b", rdata_b[0], raw_val);

    // reset right after a granted read, with a blocked write during reset
    drive(0, 1'b1, 1'b0, 12'h020, '0, '0); tick();
    idle_all();
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    clear_model_outputs();
    drive(0, 1'b1, 1'b1, 12'h010, 32'hFFFFFFFF, 4'hF); tick();
    idle_all(); tick();
    rst = 1'b0;

    // after reset the pointer is 0: port 0 wins first, then alternation
    rr_pat = '{2'b01, 2'b10, 2'b01, 2'b10};
    drive(0, 1'b1, 1'b0, 12'h008, '0, '0);
    drive(1, 1'b1, 1'b0, 12'h018, '0, '0);
    for (int k = 0; k < 4; k++) tick(1'b1, rr_pat[k]);
    idle_all(); tick();
    drive(0, 1'b1, 1'b0, 12'h010, '0, '0); tick();
    idle_all(); tick(); tick();
    check("retain_rdata_a", rdata_a[0], 32'hDEADBEEF);
    check("retain_rdata_b", rdata_b[0], 32'hDEADBEEF);

    // random traffic; a pending request is held until granted
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++)
        if (!req[p] || exp_gnt[p]) new_txn(p);
      tick();
    end
    idle_all();
    repeat (4) tick();
    for (int q = 0; q < 2*NP; q++)
      check($sformatf("drain_q%0d", q), 64'(exp_q[q].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
